gemv_stream_engine: RTL and testbench
=====================================

GEMV_STREAM_ENGINE -- requirements
Module: gemv_stream_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed element width of x, w, bias and y.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-003 SHALL have parameter TILE_SIZE, default 8: weight lanes per tile beat.
REQ-004 SHALL have parameters MAX_ROWS and MAX_COLS, both default 64: result buffer depth and x vector length.
REQ-005 SHALL have parameter DIM_WIDTH, default 10: width of the rows and cols inputs.
REQ-006 SHALL have ports clk (in, 1, clock) and rst (in, 1, asynchronous active-high reset). Reset rst is asynchronous and active-high; clock is clk.
REQ-007 SHALL have ports start (in, 1, begin job), rows (in, DIM_WIDTH, output length), cols (in, DIM_WIDTH, input length).
REQ-008 SHALL have ports out_mult (in, 16, unsigned requant multiplier) and out_shift (in, 5, requant right shift).
REQ-009 SHALL have ports x (in, MAX_COLS x DATA_WIDTH signed, input vector) and bias (in, MAX_ROWS x DATA_WIDTH signed).
REQ-010 SHALL have ports w_valid (in, 1), w_ready (out, 1) and w_tile (in, TILE_SIZE x DATA_WIDTH signed): the weight stream.
REQ-011 SHALL have ports y_valid (out, 1), y_ready (in, 1), y_data (out, DATA_WIDTH signed) and y_idx (out, DIM_WIDTH): the result stream.
REQ-012 SHALL have ports busy (out, 1), done (out, 1, one-cycle pulse) and err (out, 1, one-cycle pulse).

Function
REQ-013 SHALL use FSM states IDLE, ACCUM, DRAIN and DONE.
REQ-014 SHALL, in IDLE with start=1, latch rows, cols, out_mult and out_shift and clear the row and tile counters and the accumulator.
- Transition: IDLE->ACCUM; start is ignored outside IDLE.
REQ-015 SHALL, on start with rows=0, cols=0, rows>MAX_ROWS or cols>MAX_COLS, pulse err for one cycle and stay in IDLE.
REQ-016 SHALL stream each row as ceil(cols/TILE_SIZE) tiles; tiles never span two rows.
- Lane i of tile t multiplies x[t*TILE_SIZE+i].
- Lanes with column index >= cols contribute 0 regardless of w_tile.
REQ-017 SHALL assert w_ready=1 in every ACCUM cycle and accept a beat when w_valid and w_ready are both 1.
- Accepted beat: lane products are sign-extended to ACC_WIDTH and summed into the running accumulator; the sum is visible the next cycle.
REQ-018 SHALL, on the beat that carries a row's last tile, write accumulator + this beat's sum + sign-extended bias[row] into the result buffer entry [row].
- The same beat clears the accumulator and increments row.
- After the last row: ACCUM->DRAIN.
REQ-019 SHALL wrap accumulation modulo 2^ACC_WIDTH (no saturation).
REQ-020 SHALL, in DRAIN, present entries 0..rows-1 in order on y_data, with y_idx set to the entry index and y_valid=1.
- The index advances only when y_valid and y_ready are both 1.
- y_data/y_idx SHALL hold stable while y_valid=1 and y_ready=0.
REQ-021 SHALL compute y_data = clamp((res*out_mult + R) >>> out_shift, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1).
- R = 2^(out_shift-1), and R = 0 when out_shift = 0.
- Intermediate width SHALL be ACC_WIDTH+17 bits, so no overflow before the clamp.
REQ-022 SHALL move DRAIN->DONE on the handshake of entry rows-1.
- DONE pulses done=1 for one cycle, then returns to IDLE.
REQ-023 SHALL drive busy=1 in ACCUM, DRAIN and DONE, and busy=0 in IDLE.

Reset
REQ-024 SHALL, on rst asynchronously:
- force state IDLE;
- force w_ready, y_valid, done, err and busy to 0;
- force y_data and y_idx to 0;
- clear all counters and the accumulator.
The result buffer need not be cleared.
REQ-025 SHALL abandon a job on rst mid-operation; the next start SHALL begin a fresh job with no residue from it.

Configuration
REQ-026 SHALL support macro GEMV_STREAM_RELU_EN.
- When defined: negative post-shift values are forced to 0 before the clamp (ReLU).
- When undefined: signed output as in REQ-021.

Verification
REQ-027 Scenario: rows=2, cols=8, TILE_SIZE=8, x all 1, w row0 all 2, row1 all -1, bias {1,0}, mult=1, shift=0 -> y = {17, -8}, idx 0,1, then done.
REQ-028 Scenario: cols=10 -> 2 tiles/row; second tile has lanes 2..7 set to 100 and x[10..63]=5 -> padded lanes contribute 0.
REQ-029 Scenario: single row accumulating to 1000, mult=1, shift=2 -> y=127 (saturated); accumulating to -1000 -> y=-128 (or 0 with GEMV_STREAM_RELU_EN); accumulating to 6, shift=2 -> y=2 (rounded).
REQ-030 Scenario: y_ready held 0 for 5 cycles at idx 1 -> y_data/y_idx stable; w_valid toggled randomly -> results unchanged.
REQ-031 Scenario: start with cols=0 -> err pulse, busy stays 0; rst asserted in DRAIN -> all outputs 0 immediately; next job produces correct results.

Source files
------------

// File: rtl/gemv_stream_engine.sv
// Streaming matrix-vector engine: y = requant(W*x + bias), one tile of weights per beat.
// Define GEMV_STREAM_RELU_EN to zero negative results before the output clamp.
module gemv_stream_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int TILE_SIZE  = 8,
   parameter int MAX_ROWS   = 64,
   parameter int MAX_COLS   = 64,
   parameter int DIM_WIDTH  = 10
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [DIM_WIDTH-1:0]                  rows,
   input  logic [DIM_WIDTH-1:0]                  cols,
   input  logic [15:0]                           out_mult,
   input  logic [4:0]                            out_shift,
   input  logic [MAX_COLS-1:0][DATA_WIDTH-1:0]   x,
   input  logic [MAX_ROWS-1:0][DATA_WIDTH-1:0]   bias,
   input  logic                                  w_valid,
   output logic                                  w_ready,
   input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  w_tile,
   output logic                                  y_valid,
   input  logic                                  y_ready,
   output logic signed [DATA_WIDTH-1:0]          y_data,
   output logic [DIM_WIDTH-1:0]                  y_idx,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err
);

   localparam int PW = ACC_WIDTH + 17;
   localparam int RW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
   localparam int CW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
   localparam logic [DIM_WIDTH-1:0] MAXR = DIM_WIDTH'(MAX_ROWS);
   localparam logic [DIM_WIDTH-1:0] MAXC = DIM_WIDTH'(MAX_COLS);
   localparam logic [DIM_WIDTH-1:0] TS   = DIM_WIDTH'(TILE_SIZE);
   localparam logic [DIM_WIDTH-1:0] ONE  = DIM_WIDTH'(1);
   localparam logic signed [PW-1:0] YMAX = PW'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [PW-1:0] YMIN = ~YMAX;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t state, state_nx;

   logic [DIM_WIDTH-1:0] rows_q, cols_q, tiles_q;
   logic [DIM_WIDTH-1:0] row_q, tile_q, idx_q;
   logic [15:0]          mult_q;
   logic [4:0]           shift_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic                 err_q;

   logic signed [ACC_WIDTH-1:0] mem [MAX_ROWS];

   logic bad_dim, beat, last_tile, last_row, y_fire, last_idx;
   logic [DIM_WIDTH-1:0] col;
   logic signed [ACC_WIDTH-1:0] xe, we, beat_sum, row_sum;
   logic signed [ACC_WIDTH-1:0] res;
   logic signed [PW-1:0] prod, rnd, sum, shd, sat;

   assign bad_dim   = (rows == '0) || (cols == '0) || (rows > MAXR) || (cols > MAXC);
   assign w_ready   = (state == ACCUM);
   assign y_valid   = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign err       = err_q;
   assign beat      = w_valid && w_ready;
   assign y_fire    = y_valid && y_ready;
   assign last_tile = (tile_q == tiles_q - ONE);
   assign last_row  = (row_q == rows_q - ONE);
   assign last_idx  = (idx_q == rows_q - ONE);

   // Lanes past the row's real width are masked so padding never leaks in.
   always_comb begin
      beat_sum = '0;
      col      = '0;
      xe       = '0;
      we       = '0;
      for (int i = 0; i < TILE_SIZE; i++) begin
         col = tile_q * TS + DIM_WIDTH'(i);
         xe  = '0;
         we  = '0;
         if (col < cols_q && col < MAXC) begin
            xe = ACC_WIDTH'($signed(x[col[CW-1:0]]));
            we = ACC_WIDTH'($signed(w_tile[i]));
         end
         beat_sum = beat_sum + xe * we;
      end
   end

   assign row_sum = acc_q + beat_sum
                  + ACC_WIDTH'($signed(bias[row_q[RW-1:0]]));

   always_comb begin
      res  = mem[idx_q[RW-1:0]];
      prod = PW'(res) * $signed({{(PW - 16){1'b0}}, mult_q});
      rnd  = '0;
      if (shift_q != 5'd0)
         rnd = PW'(1) << (shift_q - 5'd1);
      sum = prod + rnd;
      shd = sum >>> shift_q;
`ifdef GEMV_STREAM_RELU_EN
      if (shd < 0)
         shd = '0;
`endif
      if (shd > YMAX)
         sat = YMAX;
      else if (shd < YMIN)
         sat = YMIN;
      else
         sat = shd;
   end

   assign y_data = y_valid ? sat[DATA_WIDTH-1:0] : '0;
   assign y_idx  = y_valid ? idx_q : '0;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start && !bad_dim) state_nx = ACCUM;
         ACCUM: if (beat && last_tile && last_row) state_nx = DRAIN;
         DRAIN: if (y_fire && last_idx) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rows_q  <= '0;
         cols_q  <= '0;
         tiles_q <= '0;
         row_q   <= '0;
         tile_q  <= '0;
         idx_q   <= '0;
         mult_q  <= '0;
         shift_q <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         err_q <= (state == IDLE) && start && bad_dim;
         unique case (state)
            IDLE: if (start && !bad_dim) begin
               rows_q  <= rows;
               cols_q  <= cols;
               tiles_q <= (cols + TS - ONE) / TS;
               mult_q  <= out_mult;
               shift_q <= out_shift;
               row_q   <= '0;
               tile_q  <= '0;
               idx_q   <= '0;
               acc_q   <= '0;
            end
            ACCUM: if (beat) begin
               if (last_tile) begin
                  acc_q  <= '0;
                  tile_q <= '0;
                  row_q  <= row_q + ONE;
               end else begin
                  acc_q  <= acc_q + beat_sum;
                  tile_q <= tile_q + ONE;
               end
            end
            DRAIN: if (y_fire) idx_q <= idx_q + ONE;
            default: ;
         endcase
      end
   end

   // Result buffer holds raw sums; requantisation happens on the way out.
   always_ff @(posedge clk) begin
      if (beat && last_tile)
         mem[row_q[RW-1:0]] <= row_sum;
   end

endmodule

// File: tb/tb_gemv_stream_engine.sv
// Scoreboard bench for gemv_stream_engine: random and directed jobs vs a
// plain-arithmetic model of W*x + bias followed by requantisation.
module tb_gemv_stream_engine;

   localparam int DW   = 8;
   localparam int AW   = 32;
   localparam int TS   = 8;
   localparam int MR   = 64;
   localparam int MC   = 64;
   localparam int DIMW = 10;

   logic clk = 1'b0;
   logic rst, start, w_valid, y_ready;
   logic [DIMW-1:0] rows, cols;
   logic [15:0] out_mult;
   logic [4:0] out_shift;
   logic [MC-1:0][DW-1:0] x;
   logic [MR-1:0][DW-1:0] bias;
   logic [TS-1:0][DW-1:0] w_tile;
   logic w_ready, y_valid, busy, done, err;
   logic signed [DW-1:0] y_data;
   logic [DIMW-1:0] y_idx;

   always #5 clk = ~clk;

   gemv_stream_engine #(
      .DATA_WIDTH(DW), .ACC_WIDTH(AW), .TILE_SIZE(TS),
      .MAX_ROWS(MR), .MAX_COLS(MC), .DIM_WIDTH(DIMW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
      .out_mult(out_mult), .out_shift(out_shift), .x(x), .bias(bias),
      .w_valid(w_valid), .w_ready(w_ready), .w_tile(w_tile),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {int idx; int data;} exp_t;
   exp_t sbq[$];
   exp_t e;

   int n_cmp = 0;
   int n_bad = 0;
   int xv[MC];
   int bv[MR];
   int W[MR][MC];

   task automatic chk(string nm, longint act, longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int rq(int res, int m, int s);
      longint v;
      v = longint'(res) * m;
      if (s > 0) v = v + (longint'(1) << (s - 1));
      v = v >>> s;
`ifdef GEMV_STREAM_RELU_EN
      if (v < 0) v = 0;
`endif
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return int'(v);
   endfunction

   // Monitor: pops the scoreboard on every output handshake.
   bit pstall = 0;
   int pd, pi;
   always @(negedge clk) begin
      if (rst) begin
         pstall = 0;
      end else begin
         if (pstall) begin
            chk("hold_data", y_data, pd);
            chk("hold_idx", y_idx, pi);
         end
         if (y_valid && y_ready) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out: idx %0d data %0d expected none",
                        y_idx, y_data);
            end else begin
               e = sbq.pop_front();
               chk("y_idx", y_idx, e.idx);
               chk("y_data", y_data, e.data);
            end
         end
         pstall = y_valid && !y_ready;
         pd = int'(y_data);
         pi = int'(y_idx);
      end
   end

   task automatic run_job(int nr, int nc, int m, int s,
                          bit gaps, bit stall, bit rst_mid);
      longint a;
      int tiles, cyc, st;
      bit acc, got;
      exp_t ex;
      for (int r = 0; r < nr; r++) begin
         a = 0;
         for (int c = 0; c < nc; c++) a += longint'(xv[c]) * W[r][c];
         a += bv[r];
         ex.idx  = r;
         ex.data = rq(int'(a), m, s);
         sbq.push_back(ex);
      end
      for (int c = 0; c < MC; c++) x[c] = DW'(xv[c]);
      for (int r = 0; r < MR; r++) bias[r] = DW'(bv[r]);
      rows = DIMW'(nr);
      cols = DIMW'(nc);
      out_mult = 16'(m);
      out_shift = 5'(s);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("w_ready_run", w_ready, 1);
      @(posedge clk); #1;
      tiles = (nc + TS - 1) / TS;
      for (int r = 0; r < nr; r++) begin
         for (int t = 0; t < tiles; t++) begin
            acc = 0;
            cyc = 0;
            while (!acc && cyc < 200) begin
               w_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
               for (int i = 0; i < TS; i++) begin
                  if (!w_valid) w_tile[i] = DW'($urandom);
                  else if (t * TS + i < nc) w_tile[i] = DW'(W[r][t * TS + i]);
                  else w_tile[i] = 8'd100;
               end
               @(negedge clk);
               acc = w_valid && w_ready;
               @(posedge clk); #1;
               cyc++;
            end
            if (!acc) chk("w_accept_timeout", 0, 1);
         end
      end
      w_valid = 0;
      cyc = 0;
      st = 0;
      got = 0;
      while (cyc < 1000) begin
         y_ready = ($urandom_range(0, 2) != 0);
         if (stall && y_valid && y_idx == 1 && st < 5) begin
            y_ready = 0;
            st++;
         end
         if (rst_mid && y_valid && y_idx == 2) begin
            rst = 1;
            #1;
            chk("rst_y_valid", y_valid, 0);
            chk("rst_y_data", y_data, 0);
            chk("rst_y_idx", y_idx, 0);
            chk("rst_busy", busy, 0);
            chk("rst_w_ready", w_ready, 0);
            chk("rst_done", done, 0);
            @(negedge clk);
            @(posedge clk); #1;
            rst = 0;
            y_ready = 0;
            sbq.delete();
            return;
         end
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_seen", got, 1);
      if (stall) chk("stall_cycles", st, 5);
      if (got) begin
         chk("busy_done", busy, 1);
         @(posedge clk); #1;
         y_ready = 0;
         @(negedge clk);
         chk("busy_idle", busy, 0);
         chk("done_pulse", done, 0);
         chk("sb_empty", sbq.size(), 0);
         @(posedge clk); #1;
      end
   endtask

   task automatic err_start(int nr, int nc);
      rows = DIMW'(nr);
      cols = DIMW'(nc);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_idle", busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic fill_rand(int lo, int hi);
      for (int c = 0; c < MC; c++) xv[c] = int'($urandom_range(0, hi - lo)) + lo;
      for (int r = 0; r < MR; r++) begin
         bv[r] = int'($urandom_range(0, 255)) - 128;
         for (int c = 0; c < MC; c++) W[r][c] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   task automatic fill_const(int xval, int wval);
      for (int c = 0; c < MC; c++) xv[c] = xval;
      for (int r = 0; r < MR; r++) begin
         bv[r] = 0;
         for (int c = 0; c < MC; c++) W[r][c] = wval;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; start = 0; w_valid = 0; y_ready = 0;
      rows = '0; cols = '0; out_mult = '0; out_shift = '0;
      x = '0; bias = '0; w_tile = '0;
      #1;
      chk("reset_w_ready", w_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_y_valid", y_valid, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_y_data", y_data, 0);
      chk("reset_y_idx", y_idx, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;

      // Basic two-row job.
      fill_const(1, 2);
      for (int c = 0; c < MC; c++) W[1][c] = -1;
      bv[0] = 1;
      run_job(2, 8, 1, 0, 0, 0, 0);

      // Padded second tile must ignore lanes past cols.
      fill_rand(-3, 3);
      for (int c = 10; c < MC; c++) xv[c] = 5;
      run_job(3, 10, 1, 2, 1, 0, 0);

      // Saturation and rounding.
      fill_const(1, 125);
      run_job(1, 8, 1, 2, 0, 0, 0);
      fill_const(1, -125);
      run_job(1, 8, 1, 2, 0, 0, 0);
      fill_const(1, 0);
      for (int c = 0; c < 6; c++) W[0][c] = 1;
      run_job(1, 8, 1, 2, 0, 0, 0);

      // Output back-pressure with random weight gaps.
      fill_rand(-128, 127);
      run_job(4, 20, 3, 9, 1, 1, 0);

      // Illegal dimensions.
      err_start(3, 0);
      err_start(0, 5);
      err_start(65, 8);
      err_start(2, 65);

      // Abandon mid-drain, then a clean job.
      fill_rand(-128, 127);
      run_job(5, 16, 1, 8, 1, 0, 1);
      fill_rand(-128, 127);
      run_job(3, 12, 2, 10, 1, 0, 0);

      for (int k = 0; k < 8; k++) begin
         fill_rand(-128, 127);
         run_job(int'($urandom_range(1, 12)), int'($urandom_range(1, 64)),
                 int'($urandom_range(1, 400)), int'($urandom_range(0, 18)),
                 1, 0, 0);
      end

      fill_rand(-128, 127);
      run_job(64, 64, 1, 14, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
